// File: rtl/updown_game_core.sv
// Number-guessing game engine: free-running LFSR, secret capture, UP/DOWN/HIT hints, WIN/LOSE tracking.
// Optional `dist` output (|guess - secret|) is compiled in when UPDOWN_DIST_EN is defined.
module updown_game_core #(
   parameter int              WIDTH     = 7,
   parameter int              RANGE_MAX = 99,
   parameter int              MAX_TRIES = 7,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 7'h60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             guess_valid,
   input  logic [WIDTH-1:0] guess_data,
   output logic             guess_ready,
   output logic             result_valid,
   output logic [1:0]       result,
   output logic [7:0]       tries_used,
   output logic             game_over,
   output logic             win,
   output logic [WIDTH-1:0] secret_out
`ifdef UPDOWN_DIST_EN
   ,
   output logic [WIDTH-1:0] dist
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_WIN  = 2'd2;
   localparam logic [1:0] ST_LOSE = 2'd3;

   localparam logic [1:0] RES_OOR  = 2'b00;
   localparam logic [1:0] RES_UP   = 2'b01;
   localparam logic [1:0] RES_DOWN = 2'b10;
   localparam logic [1:0] RES_HIT  = 2'b11;

   localparam logic [WIDTH-1:0] RANGE_MAX_W  = WIDTH'(RANGE_MAX);
   localparam logic [WIDTH-1:0] RANGE_SPAN_W = WIDTH'(RANGE_MAX + 1);
   localparam logic [7:0]       MAX_TRIES_W  = 8'(MAX_TRIES);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] lfsr_reg, lfsr_next;
   logic [WIDTH-1:0] secret_reg, secret_next;
   logic [1:0]       result_reg, result_next;
   logic [7:0]       tries_reg, tries_next;
   logic             result_valid_reg, result_valid_next;
   logic [WIDTH-1:0] dist_reg, dist_next;

   logic             guess_accept;
   logic             guess_in_range;
   logic [WIDTH-1:0] guess_diff;
   logic [WIDTH-1:0] secret_capture;

   // Galois right-shift LFSR: each bit takes its upper neighbour, XORed with the tap when bit 0 is set.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lfsr
         if (gi == WIDTH - 1) begin : g_top
            assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
         end else begin : g_mid
            assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
         end
      end
   endgenerate

   // Fold LFSR values above the range back into 0..RANGE_MAX.
   assign secret_capture = (lfsr_reg > RANGE_MAX_W) ? (lfsr_reg - RANGE_SPAN_W) : lfsr_reg;

   assign guess_accept   = guess_valid && (state_reg == ST_PLAY) && !start;
   assign guess_in_range = (guess_data <= RANGE_MAX_W);
   assign guess_diff     = (guess_data > secret_reg) ? (guess_data - secret_reg)
                                                     : (secret_reg - guess_data);

   always_comb begin
      state_next        = state_reg;
      secret_next       = secret_reg;
      result_next       = result_reg;
      tries_next        = tries_reg;
      result_valid_next = 1'b0;
      dist_next         = dist_reg;

      if (start) begin
         state_next  = ST_PLAY;
         secret_next = secret_capture;
         result_next = RES_OOR;
         tries_next  = 8'd0;
         dist_next   = '0;
      end else if (guess_accept) begin
         result_valid_next = 1'b1;
         if (!guess_in_range) begin
            result_next = RES_OOR;
            dist_next   = '0;
         end else begin
            tries_next = tries_reg + 8'd1;
            dist_next  = guess_diff;
            if (guess_data < secret_reg) begin
               result_next = RES_UP;
            end else if (guess_data > secret_reg) begin
               result_next = RES_DOWN;
            end else begin
               result_next = RES_HIT;
            end
            // A hit on the last try is still a win.
            if (guess_data == secret_reg) begin
               state_next = ST_WIN;
            end else if (tries_reg + 8'd1 == MAX_TRIES_W) begin
               state_next = ST_LOSE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         lfsr_reg         <= WIDTH'(1);
         secret_reg       <= '0;
         result_reg       <= RES_OOR;
         tries_reg        <= 8'd0;
         result_valid_reg <= 1'b0;
         dist_reg         <= '0;
      end else begin
         state_reg        <= state_next;
         lfsr_reg         <= lfsr_next;
         secret_reg       <= secret_next;
         result_reg       <= result_next;
         tries_reg        <= tries_next;
         result_valid_reg <= result_valid_next;
         dist_reg         <= dist_next;
      end
   end

   assign guess_ready  = (state_reg == ST_PLAY);
   assign result_valid = result_valid_reg;
   assign result       = result_reg;
   assign tries_used   = tries_reg;
   assign game_over    = (state_reg == ST_WIN) || (state_reg == ST_LOSE);
   assign win          = (state_reg == ST_WIN);
   assign secret_out   = secret_reg;

`ifdef UPDOWN_DIST_EN
   assign dist = dist_reg;
`else
   logic dist_unused;
   assign dist_unused = ^dist_reg;
`endif

endmodule

// File: doc/updown_game_core.md
# updown_game_core

Parametrised number-guessing game engine: the next generation of the up/down game top level, with a configurable number width, value range and attempt limit. It holds a free-running LFSR, captures a secret on `start`, accepts guesses over a valid/ready handshake, and returns UP/DOWN/HIT hints. It tracks attempts and ends each round in WIN or LOSE. It sits between the user-input/debounce logic and the display decoder and replaces the separate RNG, compare and control blocks.

## Interface
Parameters:
- `WIDTH`, 7: bit width of the secret, guesses and the LFSR.
- `RANGE_MAX`, 99: largest legal secret/guess value. Constraint: 2^WIDTH <= 2*(RANGE_MAX+1) and RANGE_MAX < 2^WIDTH.
- `MAX_TRIES`, 7: in-range guesses allowed per round, 1..255.
- `LFSR_TAPS`, 7'h60: Galois feedback mask; must be maximal-length for `WIDTH`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new round (1-cycle pulse, accepted in any state).
- `guess_valid` in 1: guess offered.
- `guess_data` in WIDTH: guessed value.
- `guess_ready` out 1: high only in PLAY.
- `result_valid` out 1: 1-cycle pulse per accepted guess.
- `result` out 2: 00 = out of range, 01 = UP (secret higher), 10 = DOWN (secret lower), 11 = HIT. Held until the next accepted guess, `start` or reset.
- `tries_used` out 8: in-range guesses consumed this round.
- `game_over` out 1: high in WIN or LOSE.
- `win` out 1: high in WIN only.
- `secret_out` out WIDTH: captured secret, for monitoring.

## Operation
- LFSR: after reset it holds 1 and advances every cycle in all states. It never reaches 0.
- Secret capture: on `start`, secret = lfsr if lfsr <= RANGE_MAX, else lfsr - (RANGE_MAX+1).
- FSM states: IDLE, PLAY, WIN, LOSE. Reset enters IDLE.
  - IDLE -> PLAY on `start`.
  - PLAY -> WIN on an accepted HIT.
  - PLAY -> LOSE on an accepted non-HIT in-range guess when tries_used+1 == MAX_TRIES.
  - WIN/LOSE -> PLAY on `start`.
  - PLAY + `start` restarts the round: new secret, tries_used = 0.
- A guess is accepted when `guess_valid && guess_ready`.
  - guess > RANGE_MAX: result = 00, no try consumed, stay in PLAY.
  - guess < secret: result = 01. guess > secret: result = 10. guess == secret: result = 11. Each of these increments tries_used.
- A HIT on the final try is a WIN, never a LOSE.
- `start` and `guess_valid` in the same cycle: `start` wins and the guess is dropped (no result_valid).
- `start` clears `result` to 00, `tries_used` to 0, and `game_over`/`win` to 0.
- Comparison is unsigned, WIDTH bits.

## Timing
- Reset values: guess_ready 0, result_valid 0, result 00, tries_used 0, game_over 0, win 0, secret_out 0, LFSR 1.
- `start` at cycle N: secret_out, PLAY state and guess_ready=1 all take effect at N+1.
- Guess accepted at cycle N: result_valid, result, tries_used, game_over and win all update at N+1 (latency 1). guess_ready drops at N+1 if the round ended.
- Back-to-back guesses are accepted every cycle while in PLAY.
- Reset mid-round: state returns to IDLE at the next edge, and any pending result is discarded.

## Configuration
- `UPDOWN_DIST_EN` defined: adds output `dist` [WIDTH-1:0] = |guess - secret|. It is registered with `result`, is 0 for out-of-range guesses and on reset/start, and is held like `result`.
- Not defined: the `dist` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `start`, then read secret_out = S (e.g. 42). Guess 10 -> result 01, tries 1. Guess 80 -> result 10, tries 2. Guess 42 -> result 11, win 1, game_over 1, guess_ready 0.
- MAX_TRIES=7, secret S: seven in-range wrong guesses -> LOSE after the 7th, tries_used 7, win 0. An 8th guess_valid is ignored (no result_valid).
- Guess 120 with RANGE_MAX=99 -> result 00, tries_used unchanged, still PLAY. Then guess S -> HIT.
- Six misses, then a HIT on the 7th try -> win 1, not LOSE.
- `start` and `guess_valid` together mid-round -> no result_valid, tries_used 0, new secret_out.
- Reset asserted during PLAY -> all outputs return to their reset values next cycle. With UPDOWN_DIST_EN: guess 30 vs secret 42 -> dist 12.
